system_worker0_cpu_mul_seq: RTL



---
 rtl/system_worker0_cpu_mul_pkg.sv | 33 +++
 rtl/system_worker0_cpu_mul_seq_if.sv | 31 +++
 rtl/system_worker0_cpu_mul_fixup.sv | 35 +++
 rtl/system_worker0_cpu_mul_seq.sv | 127 ++++++++++++
 4 files changed

// File: rtl/system_worker0_cpu_mul_pkg.sv
// Shared types for the CPU multiply sequencer: op encoding, FSM states, widths and timing.
package system_worker0_cpu_mul_pkg;

    localparam int WORD_W = 32;
    localparam int HALF_W = 16;

    // Cell passes per op and edges from request handshake to the first edge that sees rsp_valid.
    localparam int PASSES_MUL  = 1;
    localparam int PASSES_MULX = 2;
    localparam int LAT_MUL     = 3;
    localparam int LAT_MULX    = 5;

    typedef enum logic [1:0] {
        MUL_OP_MUL = 2'd0,
        MUL_OP_XUU = 2'd1,
        MUL_OP_XSU = 2'd2,
        MUL_OP_XSS = 2'd3
    } mul_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PASS1,
        ST_CAP1,
        ST_PASS2,
        ST_CAP2,
        ST_RESP
    } mul_state_e;

    function automatic logic is_mulx(input mul_op_e op);
        return op != MUL_OP_MUL;
    endfunction

endpackage

// File: rtl/system_worker0_cpu_mul_seq_if.sv
// Request, response and multiplier-cell signals of the multiply sequencer.
interface system_worker0_cpu_mul_seq_if;

    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_src1;
    logic [31:0] req_src2;
    logic [31:0] cell_src1;
    logic [31:0] cell_src2;
    logic        cell_en;
    logic [31:0] cell_p1;
    logic [31:0] cell_p2;
    logic [31:0] cell_p3;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;

    modport slave (
        input  req_valid, req_op, req_src1, req_src2,
        input  cell_p1, cell_p2, cell_p3, rsp_ready,
        output req_ready, cell_src1, cell_src2, cell_en, rsp_valid, rsp_result
    );

    modport master (
        output req_valid, req_op, req_src1, req_src2,
        output cell_p1, cell_p2, cell_p3, rsp_ready,
        input  req_ready, cell_src1, cell_src2, cell_en, rsp_valid, rsp_result
    );

endinterface

// File: rtl/system_worker0_cpu_mul_fixup.sv
// Combines hi*hi, the middle partial sum and lo*lo into a 64-bit product and returns
// its high word with the two's-complement correction for signed operands.
module system_worker0_cpu_mul_fixup
    import system_worker0_cpu_mul_pkg::*;
(
    input  logic [WORD_W-1:0] hh,
    input  logic [WORD_W:0]   mid,
    input  logic [WORD_W-1:0] p1,
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  mul_op_e           op,
    output logic [WORD_W-1:0] hi
);

    logic [2*WORD_W-1:0] full;
    logic [WORD_W-1:0]   corr_a;
    logic [WORD_W-1:0]   corr_b;

    always_comb begin
        full = {hh, {WORD_W{1'b0}}}
             + {{(WORD_W - HALF_W - 1){1'b0}}, mid, {HALF_W{1'b0}}}
             + {{WORD_W{1'b0}}, p1};
        corr_a = '0;
        corr_b = '0;
        // A negative signed operand was read as x + 2^32, adding 2^32 * other to the product.
        if ((op == MUL_OP_XSU || op == MUL_OP_XSS) && a[WORD_W-1]) begin
            corr_a = b;
        end
        if (op == MUL_OP_XSS && b[WORD_W-1]) begin
            corr_b = a;
        end
        hi = full[2*WORD_W-1:WORD_W] - corr_a - corr_b;
    end

endmodule

// File: rtl/system_worker0_cpu_mul_seq.sv
// Multiply sequencer around the 3-partial-product 16x16 cell: runs one cell pass for MUL,
// two for MULX* (second pass yields hi*hi), and holds the result until it is accepted.
//
// state    | meaning
// ST_IDLE  | ready for a request
// ST_PASS1 | cell_en high with full operands; cell registers at the end of this cycle
// ST_CAP1  | lo/mid partials captured; MUL result formed here
// ST_PASS2 | cell_en high with the operand high halves
// ST_CAP2  | hi*hi available; high word formed via fixup
// ST_RESP  | rsp_valid high until rsp_ready
module system_worker0_cpu_mul_seq
    import system_worker0_cpu_mul_pkg::*;
#(
    parameter bit SUPPORT_MULX = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    system_worker0_cpu_mul_seq_if.slave bus
);

    mul_state_e        state;
    mul_op_e           op_q;
    logic [WORD_W-1:0] a_q;
    logic [WORD_W-1:0] b_q;
    logic [WORD_W-1:0] p1_q;
    logic [WORD_W:0]   mid_q;
    logic [WORD_W:0]   mid_now;
    logic [WORD_W-1:0] lo_now;
    logic [WORD_W-1:0] hi_word;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic              cell_en_q;
    logic [WORD_W-1:0] rsp_result_q;
    logic [WORD_W-1:0] cell_src1_q;
    logic [WORD_W-1:0] cell_src2_q;

    assign mid_now = {1'b0, bus.cell_p2} + {1'b0, bus.cell_p3};
    assign lo_now  = bus.cell_p1 + {mid_now[HALF_W-1:0], {HALF_W{1'b0}}};

    system_worker0_cpu_mul_fixup u_fixup (
        .hh  (bus.cell_p1),
        .mid (mid_q),
        .p1  (p1_q),
        .a   (a_q),
        .b   (b_q),
        .op  (op_q),
        .hi  (hi_word)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            op_q         <= MUL_OP_MUL;
            a_q          <= '0;
            b_q          <= '0;
            p1_q         <= '0;
            mid_q        <= '0;
            req_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            cell_en_q    <= 1'b0;
            rsp_result_q <= '0;
            cell_src1_q  <= '0;
            cell_src2_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    req_ready_q <= 1'b1;
                    if (bus.req_valid && req_ready_q) begin
                        a_q         <= bus.req_src1;
                        b_q         <= bus.req_src2;
                        op_q        <= SUPPORT_MULX ? mul_op_e'(bus.req_op) : MUL_OP_MUL;
                        req_ready_q <= 1'b0;
                        cell_src1_q <= bus.req_src1;
                        cell_src2_q <= bus.req_src2;
                        cell_en_q   <= 1'b1;
                        state       <= ST_PASS1;
                    end
                end
                ST_PASS1: begin
                    cell_en_q <= 1'b0;
                    state     <= ST_CAP1;
                end
                ST_CAP1: begin
                    p1_q  <= bus.cell_p1;
                    mid_q <= mid_now;
                    if (!is_mulx(op_q)) begin
                        rsp_result_q <= lo_now;
                        rsp_valid_q  <= 1'b1;
                        state        <= ST_RESP;
                    end else begin
                        cell_src1_q <= {{HALF_W{1'b0}}, a_q[WORD_W-1:HALF_W]};
                        cell_src2_q <= {{HALF_W{1'b0}}, b_q[WORD_W-1:HALF_W]};
                        cell_en_q   <= 1'b1;
                        state       <= ST_PASS2;
                    end
                end
                ST_PASS2: begin
                    cell_en_q <= 1'b0;
                    state     <= ST_CAP2;
                end
                ST_CAP2: begin
                    rsp_result_q <= hi_word;
                    rsp_valid_q  <= 1'b1;
                    state        <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.cell_en    = cell_en_q;
    assign bus.cell_src1  = cell_src1_q;
    assign bus.cell_src2  = cell_src2_q;

endmodule
